// File: rtl/fifo_pkg.sv
// Shared helpers and types for the synchronous FIFO family.
package fifo_pkg;

  // Pointer width: one index bit per address bit plus a wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef enum logic {
    READ_REG  = 1'b0,
    READ_FWFT = 1'b1
  } fifo_mode_e;

endpackage

// File: rtl/fifo_ram.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous read port.
module fifo_ram #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Asynchronous read of the addressed entry.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with occupancy count, almost flags, sticky error flags and a
// selectable registered or first-word-fall-through read port.
module sync_fifo_fwft
  import fifo_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wren,
  input  logic [DATA_WIDTH-1:0]      i_data,
  input  logic                       rden,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic                       o_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [ptr_w(DEPTH)-1:0]    count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam fifo_mode_e MODE = (FWFT != 0) ? READ_FWFT : READ_REG;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "sync_fifo_fwft: DEPTH must be a power of 2 and >= 2");
  end
  if (AF_THRESH > DEPTH) begin : g_bad_af
    $fatal(1, "sync_fifo_fwft: AF_THRESH must not exceed DEPTH");
  end
  if (AE_THRESH >= DEPTH) begin : g_bad_ae
    $fatal(1, "sync_fifo_fwft: AE_THRESH must be below DEPTH");
  end

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic [PW-1:0] count_w;
  logic          empty_w, full_w;
  logic          rd_acc, wr_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Occupancy and flags come only from registered pointers, never from wren/rden.
  assign count_w = wptr_q - rptr_q;
  assign empty_w = (count_w == '0);
  assign full_w  = (count_w == DEPTH_C);

  // A pop needs data; a push needs room, or a simultaneous pop freeing a slot.
  // Empty with both requests pushes only: there is no bypass path.
  assign rd_acc = rden & ~empty_w;
  assign wr_acc = wren & (~full_w | rd_acc);

  // Next-state pointers and sticky error flags; a set wins over clr_err.
  always_comb begin
    wptr_d      = wr_acc ? wptr_q + PW'(1) : wptr_q;
    rptr_d      = rd_acc ? rptr_q + PW'(1) : rptr_q;
    overflow_d  = (wren & full_w & ~rd_acc) | (overflow_q & ~clr_err);
    underflow_d = (rden & empty_w) | (underflow_q & ~clr_err);
  end

  // Pointer and error-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr_q[AW-1:0]),
    .wdata (i_data),
    .raddr (rptr_q[AW-1:0]),
    .rdata (ram_rdata)
  );

  if (MODE == READ_REG) begin : g_read_reg
    logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
    logic                  o_valid_q, o_valid_d;

    // Capture the head on a pop; data holds otherwise, valid is a one-cycle pulse.
    always_comb begin
      o_data_d  = rd_acc ? ram_rdata : o_data_q;
      o_valid_d = rd_acc;
    end

    // Registered read-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        o_data_q  <= '0;
        o_valid_q <= 1'b0;
      end else begin
        o_data_q  <= o_data_d;
        o_valid_q <= o_valid_d;
      end
    end

    assign o_data  = o_data_q;
    assign o_valid = o_valid_q;
  end else begin : g_read_fwft
    // Head entry is always presented; its value is meaningless while empty.
    assign o_data  = ram_rdata;
    assign o_valid = ~empty_w;
  end

  assign count        = count_w;
  assign empty        = empty_w;
  assign full         = full_w;
  assign almost_full  = (count_w >= AF_C);
  assign almost_empty = (count_w <= AE_C);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Bench for sync_fifo_fwft: a registered-read and an FWFT instance share stimulus and
// are checked against a queue-based reference model, a vector table and corner sequences.
module tb_sync_fifo_fwft;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wren = 1'b0;
  logic       rden = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] i_data = 8'h00;

  logic [7:0] r_odata, f_odata;
  logic       r_ovalid, f_ovalid, r_full, f_full, r_empty, f_empty;
  logic       r_af, f_af, r_ae, f_ae, r_ovf, f_ovf, r_udf, f_udf;
  logic [3:0] r_count, f_count;

  always #5 clk = ~clk;

  sync_fifo_fwft #(.DEPTH(8), .DATA_WIDTH(8), .FWFT(0)) u_reg (
    .clk(clk), .rst_n(rst_n), .wren(wren), .i_data(i_data), .rden(rden),
    .o_data(r_odata), .o_valid(r_ovalid), .full(r_full), .empty(r_empty),
    .almost_full(r_af), .almost_empty(r_ae), .count(r_count),
    .overflow(r_ovf), .underflow(r_udf), .clr_err(clr_err)
  );

  sync_fifo_fwft #(.DEPTH(8), .DATA_WIDTH(8), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wren(wren), .i_data(i_data), .rden(rden),
    .o_data(f_odata), .o_valid(f_ovalid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf), .clr_err(clr_err)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: contents as a queue, plus sticky flags and registered read port.
  logic [7:0] mq[$];
  logic       m_ovf, m_udf, m_ovalid;
  logic [7:0] m_odata;

  typedef struct {
    logic       w;
    logic [7:0] d;
    logic       r;
    logic       c;
    int         e_count;
    logic       e_full;
    logic       e_af;
    logic       e_ovf;
    logic       e_ovalid;
    logic [7:0] e_odata;
  } vec_t;

  vec_t vt[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0; m_udf = 1'b0; m_ovalid = 1'b0; m_odata = 8'h00;
  endtask

  task automatic model_step(input logic w, input logic [7:0] d, input logic r, input logic c);
    int  n;
    bit  pop, push, oset, uset;
    n    = mq.size();
    pop  = r && (n > 0);
    push = w && ((n < 8) || pop);
    oset = w && (n == 8) && !pop;
    uset = r && (n == 0);
    m_ovalid = pop;
    if (pop) m_odata = mq.pop_front();
    if (push) mq.push_back(d);
    m_ovf = oset || (m_ovf && !c);
    m_udf = uset || (m_udf && !c);
  endtask

  task automatic check_model();
    int n;
    n = mq.size();
    chk("reg_count", 32'(r_count), 32'(n));
    chk("fwft_count", 32'(f_count), 32'(n));
    chk("reg_full", 32'(r_full), 32'(n == 8));
    chk("fwft_full", 32'(f_full), 32'(n == 8));
    chk("reg_empty", 32'(r_empty), 32'(n == 0));
    chk("fwft_empty", 32'(f_empty), 32'(n == 0));
    chk("reg_almost_full", 32'(r_af), 32'(n >= 7));
    chk("fwft_almost_full", 32'(f_af), 32'(n >= 7));
    chk("reg_almost_empty", 32'(r_ae), 32'(n <= 1));
    chk("fwft_almost_empty", 32'(f_ae), 32'(n <= 1));
    chk("reg_overflow", 32'(r_ovf), 32'(m_ovf));
    chk("fwft_overflow", 32'(f_ovf), 32'(m_ovf));
    chk("reg_underflow", 32'(r_udf), 32'(m_udf));
    chk("fwft_underflow", 32'(f_udf), 32'(m_udf));
    chk("reg_o_valid", 32'(r_ovalid), 32'(m_ovalid));
    chk("reg_o_data", 32'(r_odata), 32'(m_odata));
    chk("fwft_o_valid", 32'(f_ovalid), 32'(n != 0));
    if (n != 0) chk("fwft_o_data", 32'(f_odata), 32'(mq[0]));
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    @(negedge clk);
    wren = w; i_data = d; rden = r; clr_err = c;
    @(posedge clk);
    model_step(w, d, r, c);
    #1;
    check_model();
  endtask

  task automatic async_reset();
    @(negedge clk);
    wren = 1'b0; rden = 1'b0; clr_err = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    // Fill, overflow attempt, then drain: expectations written from the FIFO rules.
    for (int i = 0; i < 8; i++)
      vt[i] = '{w:1'b1, d:8'(8'h10 + i), r:1'b0, c:1'b0, e_count:i + 1,
                e_full:(i == 7), e_af:(i + 1 >= 7), e_ovf:1'b0, e_ovalid:1'b0, e_odata:8'h00};
    vt[8] = '{w:1'b1, d:8'hEE, r:1'b0, c:1'b0, e_count:8,
              e_full:1'b1, e_af:1'b1, e_ovf:1'b1, e_ovalid:1'b0, e_odata:8'h00};
    for (int k = 0; k < 8; k++)
      vt[9 + k] = '{w:1'b0, d:8'h00, r:1'b1, c:1'b0, e_count:7 - k,
                    e_full:1'b0, e_af:(7 - k >= 7), e_ovf:1'b1, e_ovalid:1'b1,
                    e_odata:8'(8'h10 + k)};

    model_reset();
    #12;
    // Reset state
    chk("rst_reg_empty", 32'(r_empty), 32'd1);
    chk("rst_reg_full", 32'(r_full), 32'd0);
    chk("rst_reg_count", 32'(r_count), 32'd0);
    chk("rst_reg_ae", 32'(r_ae), 32'd1);
    chk("rst_reg_valid", 32'(r_ovalid), 32'd0);
    chk("rst_reg_odata", 32'(r_odata), 32'd0);
    chk("rst_fwft_valid", 32'(f_ovalid), 32'd0);
    rst_n = 1'b1;

    // Table-driven fill / overflow / drain
    for (int i = 0; i < 17; i++) begin
      step(vt[i].w, vt[i].d, vt[i].r, vt[i].c);
      chk($sformatf("vec%0d_count", i), 32'(r_count), 32'(vt[i].e_count));
      chk($sformatf("vec%0d_full", i), 32'(r_full), 32'(vt[i].e_full));
      chk($sformatf("vec%0d_af", i), 32'(r_af), 32'(vt[i].e_af));
      chk($sformatf("vec%0d_ovf", i), 32'(r_ovf), 32'(vt[i].e_ovf));
      chk($sformatf("vec%0d_ovalid", i), 32'(r_ovalid), 32'(vt[i].e_ovalid));
      chk($sformatf("vec%0d_odata", i), 32'(r_odata), 32'(vt[i].e_odata));
    end
    step(0, 8'h00, 0, 1);

    // Interleaved traffic across pointer wrap
    for (int i = 0; i < 20; i++) step(1, 8'(8'h40 + i), (i >= 3), 0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);
    chk("wrap_empty", 32'(r_empty), 32'd1);

    // Full with simultaneous push and pop
    for (int i = 0; i < 8; i++) step(1, 8'(8'h60 + i), 0, 0);
    step(1, 8'h99, 1, 0);
    chk("full_both_count", 32'(r_count), 32'd8);
    chk("full_both_head", 32'(r_odata), 32'h60);
    chk("full_both_fwft_head", 32'(f_odata), 32'h61);
    chk("full_both_ovf", 32'(r_ovf), 32'd0);
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0);
    chk("full_both_tail", 32'(r_odata), 32'h99);

    // Empty with simultaneous push and pop: push only, underflow
    step(1, 8'h77, 1, 0);
    chk("empty_both_count", 32'(r_count), 32'd1);
    chk("empty_both_udf", 32'(r_udf), 32'd1);
    chk("empty_both_valid", 32'(r_ovalid), 32'd0);
    step(0, 8'h00, 1, 1);

    // FWFT fall-through
    step(1, 8'hA5, 0, 0);
    chk("fwft_a5_data", 32'(f_odata), 32'hA5);
    chk("fwft_a5_valid", 32'(f_ovalid), 32'd1);
    step(0, 8'h00, 1, 0);
    chk("fwft_pop_empty", 32'(f_empty), 32'd1);

    // Error flag clear and set-over-clear priority
    for (int i = 0; i < 9; i++) step(1, 8'(8'h80 + i), 0, 0);
    chk("ovf_set", 32'(r_ovf), 32'd1);
    step(0, 8'h00, 0, 1);
    chk("ovf_cleared", 32'(r_ovf), 32'd0);
    step(1, 8'hBB, 0, 1);
    chk("ovf_set_beats_clr", 32'(r_ovf), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0);
    chk("pre_reset_count", 32'(r_count), 32'd5);
    async_reset();
    chk("async_rst_count", 32'(r_count), 32'd0);
    chk("async_rst_empty", 32'(f_empty), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      int mode;
      mode = (i / 250) % 3;
      step(($urandom_range(99) < (mode == 0 ? 70 : (mode == 1 ? 30 : 50))),
           8'($urandom),
           ($urandom_range(99) < (mode == 0 ? 30 : (mode == 1 ? 70 : 50))),
           ($urandom_range(99) < 5));
      if (i == 1200) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
